// File: rtl/clint_multi_hart.sv
// Core-local interruptor: shared 64-bit mtime plus per-hart mtimecmp, msip and ssip,
// with a three-state bus handshake (Idle -> Access -> Wait) acknowledging each request once.
module clint_multi_hart #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned HART_COUNT = 2,
    parameter int unsigned PRESCALE   = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rd_en,
    input  logic                      wr_en,
    input  logic [15:0]               addr,
    input  logic [DATA_SIZE-1:0]      wr_data,
    input  logic [DATA_SIZE/8-1:0]    byte_write_enable,
    output logic [DATA_SIZE-1:0]      rd_data,
    output logic                      ack,
    output logic [63:0]               mem_mtime,
    output logic [64*HART_COUNT-1:0]  mem_mtimecmp,
    output logic [HART_COUNT-1:0]     mem_msip,
    output logic [HART_COUNT-1:0]     mem_ssip,
    output logic [HART_COUNT-1:0]     mtip
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

    state_e      state_q;
    logic [63:0] mtime_q, mtime_d;
    logic [31:0] presc_q;
    logic        tick;

    // The bus is viewed as an 8-byte aligned doubleword: data, mask and read-back in 64 bits.
    logic [63:0] wdata_w;
    logic [7:0]  be_w;
    logic [63:0] bmask;
    logic [63:0] rdata_w;
    logic [DATA_SIZE-1:0] rd_sel;

    logic do_write;
    logic in_msip, in_ssip, in_cmp, in_mtime;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];

    generate
        if (DATA_SIZE == 64) begin : g_bus64
            logic unused_addr2;
            assign unused_addr2 = addr[2];
            assign wdata_w      = 64'(wr_data);
            assign be_w         = 8'(byte_write_enable);
            assign rd_sel       = DATA_SIZE'(rdata_w);
        end else begin : g_bus32
            assign wdata_w = 64'({wr_data, wr_data});
            assign be_w    = addr[2] ? 8'({byte_write_enable, 4'h0})
                                     : 8'({4'h0, byte_write_enable});
            assign rd_sel  = DATA_SIZE'(addr[2] ? rdata_w[63:32] : rdata_w[31:0]);
        end
    endgenerate

    assign bmask = {{8{be_w[7]}}, {8{be_w[6]}}, {8{be_w[5]}}, {8{be_w[4]}},
                    {8{be_w[3]}}, {8{be_w[2]}}, {8{be_w[1]}}, {8{be_w[0]}}};

    assign in_msip  = (addr[15:12] == 4'h0);
    assign in_ssip  = (addr[15:12] == 4'h1);
    assign in_cmp   = (addr[15:12] == 4'h4);
    assign in_mtime = (addr[15:3] == 13'h17FF);
    assign do_write = (state_q == StIdle) && wr_en;

    // Read-back is ORed across harts; at most one source matches a given address.
    logic [HART_COUNT:0][63:0] rd_acc;
    assign rd_acc[0] = in_mtime ? mtime_q : 64'h0;
    assign rdata_w   = rd_acc[HART_COUNT];

    generate
        for (genvar h = 0; h < HART_COUNT; h++) begin : g_hart
            localparam int unsigned Half = h % 2;

            logic        msip_q, ssip_q, mtip_q;
            logic [63:0] cmp_q;
            logic        hit_pair, hit_cmp;
            logic [63:0] part;

            assign hit_pair = (addr[11:3] == 9'(h / 2));
            assign hit_cmp  = in_cmp && (addr[11:3] == 9'(h));

            always_comb begin
                part = 64'h0;
                if (hit_cmp) begin
                    part = cmp_q;
                end else if (in_msip && hit_pair) begin
                    part[32*Half] = msip_q;
                end else if (in_ssip && hit_pair) begin
                    part[32*Half] = ssip_q;
                end
            end

            assign rd_acc[h+1] = rd_acc[h] | part;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    msip_q <= 1'b0;
                    ssip_q <= 1'b0;
                    cmp_q  <= '1;
                    mtip_q <= 1'b0;
                end else begin
                    if (do_write && in_msip && hit_pair && be_w[4*Half]) begin
                        msip_q <= wdata_w[32*Half];
                    end
                    if (do_write && in_ssip && hit_pair && be_w[4*Half]) begin
                        ssip_q <= wdata_w[32*Half];
                    end
                    if (do_write && hit_cmp) begin
                        cmp_q <= (cmp_q & ~bmask) | (wdata_w & bmask);
                    end
                    mtip_q <= (mtime_q >= cmp_q);
                end
            end

            assign mem_msip[h]               = msip_q;
            assign mem_ssip[h]               = ssip_q;
            assign mtip[h]                   = mtip_q;
            assign mem_mtimecmp[64*h +: 64]  = cmp_q;
        end
    endgenerate

    assign tick = (presc_q == 32'(PRESCALE - 1));

    // A bus write to mtime overrides the tick: unwritten bytes keep the pre-increment value.
    always_comb begin
        mtime_d = mtime_q;
        if (do_write && in_mtime) begin
            mtime_d = (mtime_q & ~bmask) | (wdata_w & bmask);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtime_q <= 64'h0;
            presc_q <= 32'h0;
        end else begin
            mtime_q <= mtime_d;
            presc_q <= tick ? 32'h0 : presc_q + 32'd1;
        end
    end

    assign mem_mtime = mtime_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ack     <= 1'b0;
            rd_data <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rd_en || wr_en) begin
                        state_q <= StAccess;
                        ack     <= 1'b1;
                        rd_data <= rd_sel;
                    end
                end
                StAccess: begin
                    state_q <= StWait;
                    ack     <= 1'b0;
                end
                StWait: begin
                    if (!rd_en && !wr_en) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ack     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clint_multi_hart.sv
// Self-checking bench for clint_multi_hart (32-bit bus, two harts, prescale of four):
// table-driven bus vectors with a read-data scoreboard plus hand-written timer/reset sequences.
module tb_clint_multi_hart;

    localparam int unsigned DS = 32;
    localparam int unsigned HC = 2;
    localparam int unsigned PS = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            rd_en = 1'b0;
    logic            wr_en = 1'b0;
    logic [15:0]     addr = 16'h0;
    logic [DS-1:0]   wr_data = '0;
    logic [DS/8-1:0] byte_write_enable = '0;
    logic [DS-1:0]   rd_data;
    logic            ack;
    logic [63:0]     mem_mtime;
    logic [64*HC-1:0] mem_mtimecmp;
    logic [HC-1:0]   mem_msip;
    logic [HC-1:0]   mem_ssip;
    logic [HC-1:0]   mtip;

    clint_multi_hart #(
        .DATA_SIZE (DS),
        .HART_COUNT(HC),
        .PRESCALE  (PS)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .rd_en            (rd_en),
        .wr_en            (wr_en),
        .addr             (addr),
        .wr_data          (wr_data),
        .byte_write_enable(byte_write_enable),
        .rd_data          (rd_data),
        .ack              (ack),
        .mem_mtime        (mem_mtime),
        .mem_mtimecmp     (mem_mtimecmp),
        .mem_msip         (mem_msip),
        .mem_ssip         (mem_ssip),
        .mtip             (mtip)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;

    logic [31:0] exp_q[$];

    always @(negedge clock) if (ack) ack_cnt++;

    typedef struct packed {
        logic        wr;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] rd;
        logic [1:0]  msip;
        logic [1:0]  ssip;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " mtime"}, mem_mtime, 64'h0);
        check({tag, " mtimecmp0"}, mem_mtimecmp[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        check({tag, " mtimecmp1"}, mem_mtimecmp[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
        check({tag, " msip"}, 64'(mem_msip), 64'h0);
        check({tag, " ssip"}, 64'(mem_ssip), 64'h0);
        check({tag, " mtip"}, 64'(mtip), 64'h0);
        check({tag, " ack"}, 64'(ack), 64'h0);
        check({tag, " rd_data"}, 64'(rd_data), 64'h0);
    endtask

    // Drives a request and returns at the negedge where ack is seen (DUT in Access).
    task automatic bus_start(input logic wr, input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic [31:0] exp_rd, input string name);
        int n;
        if (!wr) exp_q.push_back(exp_rd);
        @(negedge clock);
        addr = a;
        wr_data = d;
        byte_write_enable = be;
        wr_en = wr;
        rd_en = !wr;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ack && n < 8);
        if (!ack) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s ack timeout: got no ack, expected ack within 8 cycles", name);
            if (!wr) void'(exp_q.pop_front());
        end else if (!wr) begin
            check({name, " rd_data"}, 64'(rd_data), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic bus_end(input string name);
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clock);
        check({name, " ack single cycle"}, 64'(ack), 64'h0);
    endtask

    vec_t vecs[18];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic found;
        int   a0;

        vecs[0]  = '{1'b0, 16'h400C, 32'h0,         4'hF, 32'hFFFF_FFFF, 2'b00, 2'b00};
        vecs[1]  = '{1'b0, 16'h4008, 32'h0,         4'hF, 32'hFFFF_FFFF, 2'b00, 2'b00};
        vecs[2]  = '{1'b1, 16'h0004, 32'h1,         4'h1, 32'h0,         2'b10, 2'b00};
        vecs[3]  = '{1'b0, 16'h0004, 32'h0,         4'hF, 32'h1,         2'b10, 2'b00};
        vecs[4]  = '{1'b1, 16'h0004, 32'h0,         4'h2, 32'h0,         2'b10, 2'b00};
        vecs[5]  = '{1'b0, 16'h0004, 32'h0,         4'hF, 32'h1,         2'b10, 2'b00};
        vecs[6]  = '{1'b1, 16'h1000, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10, 2'b01};
        vecs[7]  = '{1'b0, 16'h1000, 32'h0,         4'hF, 32'h1,         2'b10, 2'b01};
        vecs[8]  = '{1'b0, 16'h0000, 32'h0,         4'hF, 32'h0,         2'b10, 2'b01};
        vecs[9]  = '{1'b1, 16'h2000, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10, 2'b01};
        vecs[10] = '{1'b0, 16'h2000, 32'h0,         4'hF, 32'h0,         2'b10, 2'b01};
        vecs[11] = '{1'b0, 16'h0008, 32'h0,         4'hF, 32'h0,         2'b10, 2'b01};
        vecs[12] = '{1'b1, 16'h4008, 32'h1234_5678, 4'h5, 32'h0,         2'b10, 2'b01};
        vecs[13] = '{1'b0, 16'h4008, 32'h0,         4'hF, 32'hFF34_FF78, 2'b10, 2'b01};
        vecs[14] = '{1'b0, 16'h4004, 32'h0,         4'hF, 32'h1,         2'b10, 2'b01};
        vecs[15] = '{1'b1, 16'h0000, 32'hFFFF_FFFE, 4'hF, 32'h0,         2'b10, 2'b01};
        vecs[16] = '{1'b1, 16'h0000, 32'h1,         4'hE, 32'h0,         2'b10, 2'b01};
        vecs[17] = '{1'b0, 16'h0000, 32'h0,         4'hF, 32'h0,         2'b10, 2'b01};

        repeat (3) @(negedge clock);
        check_reset_state("reset");
        reset = 1'b1;

        // Prescale of four: 40 edges after release give ten ticks.
        repeat (40) @(posedge clock);
        @(negedge clock);
        check("mtime after 40 cycles", mem_mtime, 64'd10);
        check("mtip idle", 64'(mtip), 64'h0);

        bus_start(1'b1, 16'h4000, 32'd12, 4'hF, 32'h0, "cmp0 lo");
        bus_end("cmp0 lo");
        bus_start(1'b1, 16'h4004, 32'd0, 4'hF, 32'h0, "cmp0 hi");
        bus_end("cmp0 hi");
        check("cmp0 value", mem_mtimecmp[63:0], 64'd12);

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (mem_mtime == 64'd12) found = 1'b1;
        end
        check("mtime reaches 12", 64'(found), 64'h1);
        check("mtip at mtime=12", 64'(mtip), 64'h0);
        @(negedge clock);
        check("mtip one cycle later", 64'(mtip), 64'h1);

        bus_start(1'b1, 16'h4004, 32'd1, 4'h1, 32'h0, "cmp0 raise");
        check("mtip at commit", 64'(mtip), 64'h1);
        bus_end("cmp0 raise");
        check("mtip cleared", 64'(mtip), 64'h0);

        for (int i = 0; i < 18; i++) begin
            bus_start(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].be, vecs[i].rd,
                      $sformatf("vec%0d", i));
            bus_end($sformatf("vec%0d", i));
            check($sformatf("vec%0d msip", i), 64'(mem_msip), 64'(vecs[i].msip));
            check($sformatf("vec%0d ssip", i), 64'(mem_ssip), 64'(vecs[i].ssip));
        end

        // Held write: one ack, then another only after a fresh request.
        #1 a0 = ack_cnt;
        @(negedge clock);
        addr = 16'h1004;
        wr_data = 32'h1;
        byte_write_enable = 4'h1;
        wr_en = 1'b1;
        repeat (6) @(negedge clock);
        #1;
        check("held write acks", 64'(ack_cnt - a0), 64'd1);
        check("held write ssip", 64'(mem_ssip), 64'h3);
        wr_en = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("no ack after drop", 64'(ack_cnt - a0), 64'd1);
        bus_start(1'b1, 16'h1004, 32'h0, 4'h1, 32'h0, "rewrite ssip1");
        bus_end("rewrite ssip1");
        #1;
        check("ack after re-raise", 64'(ack_cnt - a0), 64'd2);
        check("ssip after re-raise", 64'(mem_ssip), 64'h1);

        // mtime wrap: high word first so no tick can carry between the halves.
        bus_start(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 32'h0, "mtime hi");
        bus_end("mtime hi");
        bus_start(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 32'h0, "mtime lo");
        check("mtime all ones", mem_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        bus_end("mtime lo");
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (mem_mtime != 64'hFFFF_FFFF_FFFF_FFFF) found = 1'b1;
            else @(negedge clock);
        end
        check("mtime wrapped", mem_mtime, 64'h0);

        // Five-cycle spacing walks the commit edge through every prescaler phase.
        for (int i = 0; i < 4; i++) begin
            repeat (2) @(negedge clock);
            bus_start(1'b1, 16'hBFF8, 32'h100 + 32'(i), 4'hF, 32'h0, "mtime phase");
            check($sformatf("mtime write phase %0d", i), mem_mtime, 64'h100 + 64'(i));
            bus_end("mtime phase");
        end

        // Reset during the Access cycle of an ssip write.
        #1 a0 = ack_cnt;
        @(negedge clock);
        addr = 16'h1000;
        wr_data = 32'h0;
        byte_write_enable = 4'h1;
        wr_en = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        wr_en = 1'b0;
        check_reset_state("mid-access reset");
        @(negedge clock);
        reset = 1'b1;
        check_reset_state("release");
        repeat (3) @(negedge clock);
        #1;
        check("no ack after reset", 64'(ack_cnt - a0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
